// File: rtl/pc_branch_sequencer_if.sv
// Fetch/branch bus between the PC sequencer and its decode, imem and compare-unit peers.
// Latency: none, wires only.
// Backpressure: stall and imem_ready travel to the sequencer on this bus.
interface pc_branch_sequencer_if #(
  parameter int ADDR_W = 8,
  parameter int CNT_W  = 16
);
  logic              stall;
  logic              imem_ready;
  logic              halt_req;
  logic              br_valid;
  logic [1:0]        br_kind;
  logic [2:0]        br_mode;
  logic [ADDR_W-1:0] br_imm;
  logic [ADDR_W-1:0] br_reg;
  logic              cmp_flag;
  logic [2:0]        cmp_mode;
  logic [ADDR_W-1:0] pc;
  logic              imem_req;
  logic              flush;
  logic              taken;
  logic              halted;
  logic [CNT_W-1:0]  br_cnt;
  logic [CNT_W-1:0]  taken_cnt;

  // Sequencer side: owns the fetch address and branch statistics.
  modport master (
    input  stall, imem_ready, halt_req, br_valid, br_kind, br_mode, br_imm, br_reg, cmp_flag,
    output cmp_mode, pc, imem_req, flush, taken, halted, br_cnt, taken_cnt
  );

  // Peer side: decode, instruction memory and compare unit.
  modport slave (
    output stall, imem_ready, halt_req, br_valid, br_kind, br_mode, br_imm, br_reg, cmp_flag,
    input  cmp_mode, pc, imem_req, flush, taken, halted, br_cnt, taken_cnt
  );
endinterface

// File: rtl/pc_branch_sequencer.sv
// Fetch-stage PC sequencer: linear fetch, branch/jump redirect via compare unit, halt, stats.
// Latency: br_valid to redirected fetch is 2 cycles (one RESOLVE bubble per branch).
// Backpressure: stall freezes everything; imem_ready=0 holds pc without a bubble.
module pc_branch_sequencer #(
  parameter int                ADDR_W   = 8,
  parameter logic [ADDR_W-1:0] RESET_PC = '0,
  parameter int                CNT_W    = 16
) (
  input logic                  clk,
  input logic                  rst_n,
  pc_branch_sequencer_if.master bus
);

  typedef enum logic [1:0] {RUN, RESOLVE, HALT} state_t;

  localparam logic [ADDR_W-1:0] PC_ONE  = {{(ADDR_W-1){1'b0}}, 1'b1};
  localparam logic [CNT_W-1:0]  CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};
  localparam logic [CNT_W-1:0]  CNT_MAX = '1;

  state_t            state;
  logic [ADDR_W-1:0] pc_q;
  logic [ADDR_W-1:0] tgt_q;
  logic              jump_q;      // kind[1]: unconditional, ignores cmp_flag
  logic [2:0]        cmp_mode_q;
  logic [CNT_W-1:0]  br_cnt_q;
  logic [CNT_W-1:0]  taken_cnt_q;

  logic resolve_now;
  logic take;

  // Resolution only happens in an unstalled RESOLVE cycle; that same cycle flushes the fetch.
  always_comb begin
    resolve_now = (state == RESOLVE) && !bus.stall;
    take        = jump_q | bus.cmp_flag;
  end

  assign bus.imem_req  = (state == RUN) && !bus.stall;
  assign bus.flush     = resolve_now;
  assign bus.taken     = resolve_now && take;
  assign bus.halted    = (state == HALT);
  assign bus.pc        = pc_q;
  assign bus.cmp_mode  = cmp_mode_q;
  assign bus.br_cnt    = br_cnt_q;
  assign bus.taken_cnt = taken_cnt_q;

  // State machine, pc and statistics; reset wins over stall and any pending branch.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state       <= RUN;
      pc_q        <= RESET_PC;
      tgt_q       <= '0;
      jump_q      <= 1'b0;
      cmp_mode_q  <= 3'd0;
      br_cnt_q    <= '0;
      taken_cnt_q <= '0;
    end else if (!bus.stall) begin
      case (state)
        RUN: begin
          if (bus.br_valid) begin
            jump_q     <= bus.br_kind[1];
            cmp_mode_q <= bus.br_mode;
            tgt_q      <= bus.br_kind[0] ? bus.br_reg : bus.br_imm;
            state      <= RESOLVE;
          end else if (bus.halt_req) begin
            state <= HALT;
          end else if (bus.imem_ready) begin
            pc_q <= pc_q + PC_ONE;
          end
        end
        RESOLVE: begin
          // Not taken leaves pc alone so the flushed fetch is simply reissued.
          if (take) begin
            pc_q <= tgt_q;
            if (taken_cnt_q != CNT_MAX) taken_cnt_q <= taken_cnt_q + CNT_ONE;
          end
          if (br_cnt_q != CNT_MAX) br_cnt_q <= br_cnt_q + CNT_ONE;
          state <= RUN;
        end
        HALT: begin
          if (!bus.halt_req) state <= RUN;
        end
        default: state <= RUN;
      endcase
    end
  end

endmodule

// File: tb/tb_pc_branch_sequencer.sv
// Directed, table-driven check of pc_branch_sequencer plus hand sequences for reset and saturation.
module tb_pc_branch_sequencer;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  pc_branch_sequencer_if #(.ADDR_W(8), .CNT_W(16)) bus ();

  pc_branch_sequencer #(.ADDR_W(8), .RESET_PC(8'h00), .CNT_W(16)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  typedef struct {
    logic       stall, rdy, halt, bv;
    logic [1:0] kind;
    logic [2:0] mode;
    logic [7:0] imm, rg;
    logic       flag;
    logic [7:0] e_pc;
    logic       e_req, e_flush, e_taken, e_halted;
    logic [2:0] e_mode;
    logic [15:0] e_br, e_tk;
  } vec_t;

  localparam int NV = 29;
  vec_t vecs [NV];
  int passed = 0;
  int total  = 0;

  function automatic vec_t mk(
    input logic s, input logic r, input logic h, input logic b, input logic [1:0] k,
    input logic [2:0] m, input logic [7:0] im, input logic [7:0] rg, input logic f,
    input logic [7:0] epc, input logic ereq, input logic efl, input logic etk, input logic ehl,
    input logic [2:0] em, input logic [15:0] ebr, input logic [15:0] etc);
    vec_t v;
    v.stall = s; v.rdy = r; v.halt = h; v.bv = b; v.kind = k; v.mode = m;
    v.imm = im; v.rg = rg; v.flag = f;
    v.e_pc = epc; v.e_req = ereq; v.e_flush = efl; v.e_taken = etk; v.e_halted = ehl;
    v.e_mode = em; v.e_br = ebr; v.e_tk = etc;
    return v;
  endfunction

  task automatic chk(input string name, input int idx, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s step %0d: got %0h expected %0h", name, idx, act, exp);
  endtask

  task automatic idle();
    bus.stall = 0; bus.imem_ready = 0; bus.halt_req = 0; bus.br_valid = 0;
    bus.br_kind = 0; bus.br_mode = 0; bus.br_imm = 0; bus.br_reg = 0; bus.cmp_flag = 0;
  endtask

  initial begin
    //            st rdy hlt bv kind mode imm    reg    flg  pc     req fl tk hl cm br tk
    vecs[0]  = mk(0, 1, 0, 0, 2'd0, 3'd0, 8'h00, 8'h00, 0, 8'h00, 1, 0, 0, 0, 3'd0, 0, 0);
    vecs[1]  = mk(0, 1, 0, 0, 2'd0, 3'd0, 8'h00, 8'h00, 0, 8'h01, 1, 0, 0, 0, 3'd0, 0, 0);
    vecs[2]  = mk(0, 1, 0, 0, 2'd0, 3'd0, 8'h00, 8'h00, 0, 8'h02, 1, 0, 0, 0, 3'd0, 0, 0);
    vecs[3]  = mk(0, 1, 0, 0, 2'd0, 3'd0, 8'h00, 8'h00, 0, 8'h03, 1, 0, 0, 0, 3'd0, 0, 0);
    vecs[4]  = mk(0, 1, 0, 0, 2'd0, 3'd0, 8'h00, 8'h00, 0, 8'h04, 1, 0, 0, 0, 3'd0, 0, 0);
    vecs[5]  = mk(0, 0, 0, 1, 2'd0, 3'd2, 8'h40, 8'h00, 0, 8'h05, 1, 0, 0, 0, 3'd0, 0, 0);
    vecs[6]  = mk(0, 0, 0, 0, 2'd0, 3'd0, 8'h00, 8'h00, 1, 8'h05, 0, 1, 1, 0, 3'd2, 0, 0);
    vecs[7]  = mk(0, 0, 0, 1, 2'd2, 3'd1, 8'h05, 8'h00, 0, 8'h40, 1, 0, 0, 0, 3'd2, 1, 1);
    vecs[8]  = mk(0, 0, 0, 0, 2'd0, 3'd0, 8'h00, 8'h00, 0, 8'h40, 0, 1, 1, 0, 3'd1, 1, 1);
    vecs[9]  = mk(0, 0, 0, 1, 2'd1, 3'd3, 8'h22, 8'h33, 0, 8'h05, 1, 0, 0, 0, 3'd1, 2, 2);
    vecs[10] = mk(0, 0, 0, 0, 2'd0, 3'd0, 8'h00, 8'h00, 0, 8'h05, 0, 1, 0, 0, 3'd3, 2, 2);
    vecs[11] = mk(0, 1, 0, 0, 2'd0, 3'd0, 8'h00, 8'h00, 0, 8'h05, 1, 0, 0, 0, 3'd3, 3, 2);
    vecs[12] = mk(0, 0, 0, 1, 2'd3, 3'd4, 8'h11, 8'h80, 0, 8'h06, 1, 0, 0, 0, 3'd3, 3, 2);
    vecs[13] = mk(0, 0, 0, 0, 2'd0, 3'd0, 8'h00, 8'h00, 0, 8'h06, 0, 1, 1, 0, 3'd4, 3, 2);
    vecs[14] = mk(0, 0, 1, 1, 2'd0, 3'd5, 8'h90, 8'h00, 0, 8'h80, 1, 0, 0, 0, 3'd4, 4, 3);
    vecs[15] = mk(1, 0, 1, 0, 2'd0, 3'd0, 8'h00, 8'h00, 1, 8'h80, 0, 0, 0, 0, 3'd5, 4, 3);
    vecs[16] = mk(1, 0, 1, 0, 2'd0, 3'd0, 8'h00, 8'h00, 1, 8'h80, 0, 0, 0, 0, 3'd5, 4, 3);
    vecs[17] = mk(1, 0, 1, 0, 2'd0, 3'd0, 8'h00, 8'h00, 1, 8'h80, 0, 0, 0, 0, 3'd5, 4, 3);
    vecs[18] = mk(0, 0, 1, 0, 2'd0, 3'd0, 8'h00, 8'h00, 1, 8'h80, 0, 1, 1, 0, 3'd5, 4, 3);
    vecs[19] = mk(0, 1, 1, 0, 2'd0, 3'd0, 8'h00, 8'h00, 0, 8'h90, 1, 0, 0, 0, 3'd5, 5, 4);
    vecs[20] = mk(0, 1, 1, 1, 2'd2, 3'd0, 8'h12, 8'h00, 0, 8'h90, 0, 0, 0, 1, 3'd5, 5, 4);
    vecs[21] = mk(0, 1, 0, 1, 2'd2, 3'd0, 8'h12, 8'h00, 0, 8'h90, 0, 0, 0, 1, 3'd5, 5, 4);
    vecs[22] = mk(0, 1, 0, 0, 2'd0, 3'd0, 8'h00, 8'h00, 0, 8'h90, 1, 0, 0, 0, 3'd5, 5, 4);
    vecs[23] = mk(1, 1, 0, 0, 2'd0, 3'd0, 8'h00, 8'h00, 0, 8'h91, 0, 0, 0, 0, 3'd5, 5, 4);
    vecs[24] = mk(0, 0, 0, 1, 2'd2, 3'd6, 8'hFF, 8'h00, 0, 8'h91, 1, 0, 0, 0, 3'd5, 5, 4);
    vecs[25] = mk(0, 0, 0, 0, 2'd0, 3'd0, 8'h00, 8'h00, 0, 8'h91, 0, 1, 1, 0, 3'd6, 5, 4);
    vecs[26] = mk(0, 1, 0, 0, 2'd0, 3'd0, 8'h00, 8'h00, 0, 8'hFF, 1, 0, 0, 0, 3'd6, 6, 5);
    vecs[27] = mk(0, 1, 0, 0, 2'd0, 3'd0, 8'h00, 8'h00, 0, 8'h00, 1, 0, 0, 0, 3'd6, 6, 5);
    vecs[28] = mk(0, 0, 0, 1, 2'd0, 3'd7, 8'h20, 8'h00, 0, 8'h01, 1, 0, 0, 0, 3'd6, 6, 5);

    // Reset state
    idle();
    rst_n = 0;
    repeat (2) @(posedge clk);
    #1 rst_n = 1;
    @(negedge clk);
    chk("rst_pc", -1, bus.pc, 8'h00);
    chk("rst_req", -1, bus.imem_req, 1);
    chk("rst_halted", -1, bus.halted, 0);
    chk("rst_mode", -1, bus.cmp_mode, 0);
    chk("rst_brcnt", -1, bus.br_cnt, 0);
    chk("rst_tkcnt", -1, bus.taken_cnt, 0);

    // Table: inputs applied after one edge, outputs checked before the next
    for (int i = 0; i < NV; i++) begin
      @(posedge clk);
      #1;
      bus.stall = vecs[i].stall; bus.imem_ready = vecs[i].rdy; bus.halt_req = vecs[i].halt;
      bus.br_valid = vecs[i].bv; bus.br_kind = vecs[i].kind; bus.br_mode = vecs[i].mode;
      bus.br_imm = vecs[i].imm; bus.br_reg = vecs[i].rg; bus.cmp_flag = vecs[i].flag;
      @(negedge clk);
      chk("pc", i, bus.pc, vecs[i].e_pc);
      chk("imem_req", i, bus.imem_req, vecs[i].e_req);
      chk("flush", i, bus.flush, vecs[i].e_flush);
      chk("taken", i, bus.taken, vecs[i].e_taken);
      chk("halted", i, bus.halted, vecs[i].e_halted);
      chk("cmp_mode", i, bus.cmp_mode, vecs[i].e_mode);
      chk("br_cnt", i, bus.br_cnt, vecs[i].e_br);
      chk("taken_cnt", i, bus.taken_cnt, vecs[i].e_tk);
    end

    // Reset asserted while in RESOLVE and stalled: reset must win
    @(posedge clk);
    #1 idle(); bus.stall = 1; rst_n = 0;
    @(negedge clk);
    chk("resolve_stall_flush", 100, bus.flush, 0);
    chk("resolve_mode", 100, bus.cmp_mode, 3'd7);
    @(posedge clk);
    #1 rst_n = 1; bus.stall = 0;
    @(negedge clk);
    chk("rst2_pc", 101, bus.pc, 8'h00);
    chk("rst2_req", 101, bus.imem_req, 1);
    chk("rst2_flush", 101, bus.flush, 0);
    chk("rst2_mode", 101, bus.cmp_mode, 0);
    chk("rst2_brcnt", 101, bus.br_cnt, 0);

    // Saturation: preset taken_cnt to all-ones, then one more taken jump
    force dut.taken_cnt_q = 16'hFFFF;
    #1 release dut.taken_cnt_q;
    #1 chk("sat_preset", 102, bus.taken_cnt, 16'hFFFF);
    @(posedge clk);
    #1 bus.br_valid = 1; bus.br_kind = 2'd2; bus.br_imm = 8'h30; bus.br_mode = 3'd1;
    @(posedge clk);
    #1 idle();
    @(negedge clk);
    chk("sat_flush", 103, bus.flush, 1);
    chk("sat_taken", 103, bus.taken, 1);
    @(posedge clk);
    #1;
    @(negedge clk);
    chk("sat_pc", 104, bus.pc, 8'h30);
    chk("sat_tkcnt", 104, bus.taken_cnt, 16'hFFFF);
    chk("sat_brcnt", 104, bus.br_cnt, 1);
    chk("sat_mode", 104, bus.cmp_mode, 3'd1);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
